// File: rtl/fb_pkg.sv
// Shared frame-store bus types and geometry.
// Used by the responder, its interface and the bench.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } fsr_state_t;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT / 4;
    localparam int DE_ADDR_W = 18;
    localparam int DE_DATA_W = 32;
    localparam int WS_W      = 4;

endpackage

// File: rtl/frame_store_responder_if.sv
// Drawing-engine frame-store request bus.
// The initiator drives req/fields, the responder drives ack/read data.
interface frame_store_responder_if #(
    parameter int ADDR_W = 18
);
    import fb_pkg::*;

    logic                 de_req;
    logic                 de_ack;
    logic [ADDR_W-1:0]    de_addr;
    logic [3:0]           de_nbyte;
    logic                 de_rnw;
    logic [DE_DATA_W-1:0] de_w_data;
    logic [DE_DATA_W-1:0] de_r_data;

    modport master (
        output de_req,
        output de_addr,
        output de_nbyte,
        output de_rnw,
        output de_w_data,
        input  de_ack,
        input  de_r_data
    );

    modport slave (
        input  de_req,
        input  de_addr,
        input  de_nbyte,
        input  de_rnw,
        input  de_w_data,
        output de_ack,
        output de_r_data
    );

endinterface

// File: rtl/fsr_wait_timer.sv
// Loadable down-counter with zero flag.
// Load has priority over decrement; it stops at zero.
module fsr_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/frame_store_responder.sv
// Frame-store bus responder: one word per request onto a
// byte-lane SRAM port with wait states, range check and counter.
module frame_store_responder
    import fb_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int FB_WORDS    = fb_pkg::FB_WORDS,
    parameter int ADDR_W      = DE_ADDR_W,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frame_store_responder_if.slave de,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [3:0]           sram_be,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DE_DATA_W-1:0] sram_wdata,
    input  logic [DE_DATA_W-1:0] sram_rdata,
    output logic                 err_flag,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     xfer_count
);

    localparam logic [WS_W-1:0]   WS  = WS_W'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] LIM = ADDR_W'(FB_WORDS);

    fsr_state_t r_state;
    fsr_state_t w_next;

    logic w_accept;
    logic w_done;
    logic w_zero;
    logic w_oor;
    logic w_live;

    logic                 r_ack;
    logic                 r_cs;
    logic                 r_we;
    logic                 r_rnw;
    logic                 r_oor;
    logic [3:0]           r_be;
    logic [ADDR_W-1:0]    r_addr;
    logic [DE_DATA_W-1:0] r_wdata;
    logic [DE_DATA_W-1:0] r_rdata;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt;

    // A live access touches the SRAM; out-of-range and
    // no-lane writes only run the timing.
    assign w_oor  = (de.de_addr >= LIM);
    assign w_live = !w_oor &&
                    (de.de_rnw || (de.de_nbyte != 4'hF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (de.de_req) begin
                    w_next   = ACCESS;
                    w_accept = 1'b1;
                end
            end
            ACCESS: begin
                if (w_zero) begin
                    w_next = ACK;
                    w_done = 1'b1;
                end
            end
            ACK: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    fsr_wait_timer #(
        .W (WS_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_val  (WS),
        .i_dec  (r_state == ACCESS),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_rnw   <= 1'b1;
            r_oor   <= 1'b0;
            r_be    <= 4'h0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= ~de.de_rnw;
            r_rnw   <= de.de_rnw;
            r_oor   <= w_oor;
            r_be    <= de.de_rnw ? 4'hF : ~de.de_nbyte;
            r_addr  <= de.de_addr;
            r_wdata <= de.de_w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs    <= 1'b0;
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= w_done;
            if (w_accept) begin
                r_cs <= w_live;
            end else if (w_done) begin
                r_cs <= 1'b0;
            end
            if (w_done && r_rnw) begin
                r_rdata <= r_oor ? '0 : sram_rdata;
            end
        end
    end

    // A new error in the ACK cycle beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if ((r_state == ACK) && r_oor) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (r_state == ACK) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign de.de_ack    = r_ack;
    assign de.de_r_data = r_rdata;
    assign sram_cs      = r_cs;
    assign sram_we      = r_we;
    assign sram_be      = r_be;
    assign sram_addr    = r_addr;
    assign sram_wdata   = r_wdata;
    assign err_flag     = r_err;
    assign xfer_count   = r_cnt;

endmodule

// File: tb/tb_frame_store_responder.sv
// Directed bench for frame_store_responder with a small
// byte-lane SRAM model and a second zero-wait-state build.
module tb_frame_store_responder;
    import fb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    frame_store_responder_if #(.ADDR_W(18)) bus ();
    frame_store_responder_if #(.ADDR_W(18)) bus0 ();

    logic        sram_cs, sram_we, err_flag, err_clr;
    logic [3:0]  sram_be;
    logic [17:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [15:0] xfer_count;

    logic        s0_cs, s0_we, s0_err;
    logic [3:0]  s0_be;
    logic [17:0] s0_addr;
    logic [31:0] s0_wdata;
    logic [15:0] s0_count;

    logic [31:0] mem [0:15];

    frame_store_responder #(
        .WAIT_STATES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .de         (bus),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .err_flag   (err_flag),
        .err_clr    (err_clr),
        .xfer_count (xfer_count)
    );

    frame_store_responder #(
        .WAIT_STATES (0)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .de         (bus0),
        .sram_cs    (s0_cs),
        .sram_we    (s0_we),
        .sram_be    (s0_be),
        .sram_addr  (s0_addr),
        .sram_wdata (s0_wdata),
        .sram_rdata (32'h0),
        .err_flag   (s0_err),
        .err_clr    (1'b0),
        .xfer_count (s0_count)
    );

    assign sram_rdata = mem[sram_addr[3:0]];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (sram_cs && sram_we) begin
            for (int b = 0; b < 4; b++)
                if (sram_be[b])
                    mem[sram_addr[3:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the ack cycle.
    task automatic xfer(input logic [17:0] a, input logic [3:0] nb,
                        input logic rnw, input logic [31:0] wd,
                        input logic hold, output int lat,
                        output int cs_first, output int cs_n);
        int c0;
        lat = -1;
        cs_first = -1;
        cs_n = 0;
        bus.de_req = 1'b1;
        bus.de_addr = a;
        bus.de_nbyte = nb;
        bus.de_rnw = rnw;
        bus.de_w_data = wd;
        c0 = cyc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sram_cs) begin
                if (cs_first < 0) cs_first = cyc - c0;
                cs_n++;
            end
            if (bus.de_ack) begin
                lat = cyc - c0;
                break;
            end
        end
        if (!hold) bus.de_req = 1'b0;
    endtask

    int lat, csf, csn, c0;

    initial begin
        bus.de_req = 0; bus.de_addr = 0; bus.de_nbyte = 4'hF;
        bus.de_rnw = 1; bus.de_w_data = 0;
        bus0.de_req = 0; bus0.de_addr = 0; bus0.de_nbyte = 4'hF;
        bus0.de_rnw = 1; bus0.de_w_data = 0;
        err_clr = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, bus.de_ack}, 0);
        chk("rst_cs", {31'b0, sram_cs}, 0);
        chk("rst_we", {31'b0, sram_we}, 0);
        chk("rst_be", {28'b0, sram_be}, 0);
        chk("rst_addr", {14'b0, sram_addr}, 0);
        chk("rst_wdata", sram_wdata, 0);
        chk("rst_rdata", bus.de_r_data, 0);
        chk("rst_err", {31'b0, err_flag}, 0);
        chk("rst_cnt", {16'b0, xfer_count}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(18'd5, 4'b1110, 1'b0, 32'hA5A5A5A5, 1'b0, lat, csf, csn);
        chk("t1_lat", lat, 3);
        chk("t1_cs_first", csf, 1);
        chk("t1_cs_len", csn, 2);
        chk("t1_be", {28'b0, sram_be}, 32'h1);
        chk("t1_we", {31'b0, sram_we}, 1);
        chk("t1_addr", {14'b0, sram_addr}, 5);
        @(negedge clk);
        chk("t1_cnt", {16'b0, xfer_count}, 1);

        xfer(18'd5, 4'b0000, 1'b1, 32'h0, 1'b0, lat, csf, csn);
        chk("t2_lat", lat, 3);
        chk("t2_rdata", bus.de_r_data, 32'h000000A5);
        chk("t2_be", {28'b0, sram_be}, 32'hF);
        chk("t2_we", {31'b0, sram_we}, 0);
        repeat (2) @(negedge clk);
        chk("t2_hold", bus.de_r_data, 32'h000000A5);
        chk("t2_cnt", {16'b0, xfer_count}, 2);

        xfer(18'd0, 4'b0000, 1'b0, 32'h11111111, 1'b1, lat, csf, csn);
        chk("t3_lat0", lat, 3);
        xfer(18'd1, 4'b0000, 1'b0, 32'h22222222, 1'b1, lat, csf, csn);
        chk("t3_gap1", lat, 4);
        xfer(18'd2, 4'b0000, 1'b0, 32'h33333333, 1'b0, lat, csf, csn);
        chk("t3_gap2", lat, 4);
        @(negedge clk);
        chk("t3_mem0", mem[0], 32'h11111111);
        chk("t3_mem1", mem[1], 32'h22222222);
        chk("t3_mem2", mem[2], 32'h33333333);
        chk("t3_cnt", {16'b0, xfer_count}, 5);

        xfer(18'd76800, 4'b0000, 1'b0, 32'hDEADBEEF, 1'b0, lat, csf, csn);
        chk("t4_lat", lat, 3);
        chk("t4_cs", csn, 0);
        @(negedge clk);
        chk("t4_err", {31'b0, err_flag}, 1);
        chk("t4_mem0", mem[0], 32'h11111111);
        xfer(18'd76800, 4'b0000, 1'b1, 32'h0, 1'b0, lat, csf, csn);
        chk("t4_rd_lat", lat, 3);
        chk("t4_rd_cs", csn, 0);
        chk("t4_rd_zero", bus.de_r_data, 0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_clr", {31'b0, err_flag}, 0);
        err_clr = 1'b1;
        xfer(18'd76801, 4'b0000, 1'b0, 32'h0, 1'b0, lat, csf, csn);
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_clr_vs_err", {31'b0, err_flag}, 1);
        chk("t4_cnt", {16'b0, xfer_count}, 8);

        xfer(18'd3, 4'b1111, 1'b0, 32'hFFFFFFFF, 1'b0, lat, csf, csn);
        chk("t5_lat", lat, 3);
        chk("t5_cs", csn, 0);
        @(negedge clk);
        chk("t5_mem3", mem[3], 0);
        chk("t5_cnt", {16'b0, xfer_count}, 9);

        bus0.de_req = 1'b1;
        bus0.de_addr = 18'd1;
        bus0.de_nbyte = 4'b0000;
        bus0.de_rnw = 1'b0;
        bus0.de_w_data = 32'h12345678;
        c0 = cyc;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus0.de_ack) begin
                lat = cyc - c0;
                break;
            end
        end
        bus0.de_req = 1'b0;
        chk("t5_ws0_lat", lat, 2);
        @(negedge clk);
        chk("t5_ws0_cnt", {16'b0, s0_count}, 1);

        bus.de_req = 1'b1;
        bus.de_addr = 18'd4;
        bus.de_nbyte = 4'b0000;
        bus.de_rnw = 1'b0;
        bus.de_w_data = 32'hCAFEF00D;
        @(negedge clk);
        chk("t6_cs_pre", {31'b0, sram_cs}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_cs", {31'b0, sram_cs}, 0);
        chk("t6_ack", {31'b0, bus.de_ack}, 0);
        chk("t6_cnt", {16'b0, xfer_count}, 0);
        bus.de_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_ack", {31'b0, bus.de_ack}, 0);
        end
        xfer(18'd6, 4'b0000, 1'b0, 32'h0BADCAFE, 1'b0, lat, csf, csn);
        chk("t6_lat", lat, 3);
        @(negedge clk);
        chk("t6_cnt_after", {16'b0, xfer_count}, 1);
        chk("t6_mem6", mem[6], 32'h0BADCAFE);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
